// File: rtl/mem_wide_narrow_sched.sv
// mem_wide_narrow_sched
// Owns the wide/narrow select of a tile's bank multiplexer. Narrow traffic is
// drained and every bank must be ready before the banks go to the wide port,
// so a wide request is always granted at once. Starvation is bounded both ways.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   narrow_valid_i      raw per-port narrow request valid (before gating)
//   narrow_hold_o       1 = mask this port's valid/ready toward the mux
//   wide_valid_i        raw wide request valid
//   wide_ready_i        wide ready from the mux
//   wide_gate_o         1 = pass wide valid to the mux
//   out_req_valid_i     mux output request valid, per bank
//   out_req_ready_i     bank ready
//   out_rsp_valid_i     bank response valid
//   out_rsp_ready_i     bank response ready
//   out_rsp_wide_i      response tag, 1 = wide response
//   sel_wide_o          drives the mux sel_wide_i
//   err_o               sticky protocol error, cleared only by reset
module mem_wide_narrow_sched #(
    parameter int unsigned NrPorts        = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned WideWaitMax    = 8,
    parameter int unsigned WideBurstMax   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NrPorts-1:0] narrow_valid_i,
    output logic [NrPorts-1:0] narrow_hold_o,
    input  logic               wide_valid_i,
    input  logic               wide_ready_i,
    output logic               wide_gate_o,
    input  logic [NrPorts-1:0] out_req_valid_i,
    input  logic [NrPorts-1:0] out_req_ready_i,
    input  logic [NrPorts-1:0] out_rsp_valid_i,
    input  logic [NrPorts-1:0] out_rsp_ready_i,
    input  logic [NrPorts-1:0] out_rsp_wide_i,
    output logic               sel_wide_o,
    output logic               err_o
);

    localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
    localparam int unsigned WaitW = $clog2(WideWaitMax + 1);
    localparam int unsigned BeatW = $clog2(WideBurstMax + 1);

    localparam logic [CntW-1:0]  CntMax  = CntW'(MaxOutstanding);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(WideWaitMax);
    localparam logic [BeatW-1:0] BeatMax = BeatW'(WideBurstMax);

    typedef enum logic [1:0] {
        ST_NARROW = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_WIDE   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CntW-1:0]    cnt      [NrPorts];
    logic [CntW-1:0]    cnt_next [NrPorts];
    logic [WaitW-1:0]   wwait;
    logic [WaitW-1:0]   wwait_next;
    logic [BeatW-1:0]   wbeat;
    logic [BeatW-1:0]   wbeat_next;
    logic [NrPorts-1:0] inc;
    logic [NrPorts-1:0] dec;
    logic               banks_idle;
    logic               cnt_err;
    logic               wide_err;

    // Narrow issue only counts while the banks face the narrow ports; wide
    // responses never touch the narrow counters.
    assign inc = out_req_valid_i & out_req_ready_i & {NrPorts{state != ST_WIDE}};
    assign dec = out_rsp_valid_i & out_rsp_ready_i & ~out_rsp_wide_i;

    // Per-port outstanding counters. Simultaneous issue and retire is a net
    // zero and therefore never an overflow or underflow.
    always_comb begin
        cnt_err    = 1'b0;
        banks_idle = 1'b1;
        for (int i = 0; i < int'(NrPorts); i++) begin
            cnt_next[i] = cnt[i];
            if (cnt[i] != '0) begin
                banks_idle = 1'b0;
            end
            if (inc[i] && !dec[i]) begin
                if (cnt[i] == CntMax) begin
                    cnt_err = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CntW'(1);
                end
            end else if (dec[i] && !inc[i]) begin
                if (cnt[i] == '0) begin
                    cnt_err = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] - CntW'(1);
                end
            end
        end
    end

    // Next state, wide wait and burst counters.
    always_comb begin
        state_next = state;
        wwait_next = '0;
        wbeat_next = wbeat;

        if (state == ST_NARROW && wide_valid_i) begin
            wwait_next = (wwait == WaitMax) ? wwait : wwait + WaitW'(1);
        end

        case (state)
            ST_NARROW: begin
                if (wide_valid_i && (narrow_valid_i == '0 || wwait == WaitMax)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!wide_valid_i) begin
                    state_next = ST_NARROW;
                end else if (banks_idle && (&out_req_ready_i)) begin
                    state_next = ST_WIDE;
                    wbeat_next = '0;
                end
            end
            ST_WIDE: begin
                // A beat accepted in the exit cycle still completes.
                if (wide_valid_i && wide_ready_i && wbeat != BeatMax) begin
                    wbeat_next = wbeat + BeatW'(1);
                end
                if (!wide_valid_i || (wbeat == BeatMax && (|narrow_valid_i))) begin
                    state_next = ST_NARROW;
                end
            end
            default: begin
                state_next = ST_NARROW;
            end
        endcase
    end

    // The mux must grant a wide request in the same cycle while in WIDE.
    assign wide_err = (state == ST_WIDE) && wide_valid_i && !wide_ready_i;

    // State, counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_NARROW;
            wwait       <= '0;
            wbeat       <= '0;
            sel_wide_o  <= 1'b0;
            wide_gate_o <= 1'b0;
            err_o       <= 1'b0;
            for (int i = 0; i < int'(NrPorts); i++) begin
                cnt[i] <= '0;
            end
        end else begin
            state       <= state_next;
            wwait       <= wwait_next;
            wbeat       <= wbeat_next;
            sel_wide_o  <= (state_next == ST_WIDE);
            wide_gate_o <= (state_next == ST_WIDE);
            err_o       <= err_o | cnt_err | wide_err;
            for (int i = 0; i < int'(NrPorts); i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // Combinational from registered state so a port is masked the same cycle
    // it is throttled or the banks leave narrow mode.
    always_comb begin
        for (int i = 0; i < int'(NrPorts); i++) begin
            narrow_hold_o[i] = (state != ST_NARROW) || (cnt[i] == CntMax);
        end
    end

endmodule
